// File: rtl/conv_lb_seq_if.sv
// rtl/conv_lb_seq_if.sv - pixel stream input, kernel ready and line-buffer control bundle
interface conv_lb_seq_if #(
    parameter int LB_N = 2
);
    logic            in_vld_i;
    logic            in_rdy_o;
    logic            in_sof_i;
    logic            in_sol_i;
    logic            in_eol_i;
    logic            in_eof_i;
    logic            out_rdy_i;
    logic [LB_N-1:0] lb_push_o;
    logic [LB_N-1:0] lb_pop_o;
    logic [LB_N-1:0] lb_sol_o;
    logic [LB_N-1:0] lb_eol_o;
    logic            win_vld_o;
    logic            win_eol_o;

    modport master (
        output in_vld_i, in_sof_i, in_sol_i, in_eol_i, in_eof_i, out_rdy_i,
        input  in_rdy_o, lb_push_o, lb_pop_o, lb_sol_o, lb_eol_o, win_vld_o, win_eol_o
    );

    modport slave (
        input  in_vld_i, in_sof_i, in_sol_i, in_eol_i, in_eof_i, out_rdy_i,
        output in_rdy_o, lb_push_o, lb_pop_o, lb_sol_o, lb_eol_o, win_vld_o, win_eol_o
    );
endinterface

// File: rtl/conv_lb_seq.sv
// rtl/conv_lb_seq.sv - line-buffer chain sequencer; frame/stall counters built under CONV_LB_SEQ_STATS_EN
module conv_lb_seq #(
    parameter int LB_N  = 2,
    parameter int W_MAX = 1920,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         arst,
    conv_lb_seq_if.slave bus,
    output logic         err_o,
    output logic [15:0]  frame_cnt_o,
    output logic [31:0]  stall_cnt_o
);
    localparam int CW = (W_MAX > 1) ? $clog2(W_MAX) : 1;
    localparam int RW = $clog2(LB_N + 1);
    localparam int D  = LAT * (LB_N + 1);

    typedef enum logic [1:0] {IDLE, FILL, STEADY} state_t;

    typedef struct packed {
        logic          push;
        logic          sol;
        logic          eol;
        logic          win;
        logic [RW-1:0] rows;
    } slot_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rows_q, rows_d, rows_cur;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic          err_q, err_d;
    logic          acc, fault, keep, frame_done;
    slot_t         head;
    slot_t         pipe_q [D];

    // Reset also blanks the combinational stage-0 outputs.
    assign acc          = bus.in_vld_i & bus.out_rdy_i & ~arst;
    assign bus.in_rdy_o = bus.out_rdy_i;
    assign err_o        = err_q;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        col_d      = col_q;
        err_d      = err_q;
        fault      = 1'b0;
        keep       = 1'b0;
        frame_done = 1'b0;
        rows_cur   = (state_q == IDLE) ? '0 : rows_q;
        cur_col    = bus.in_sol_i ? '0 : col_q;
        if (acc) begin
            fault = ((state_q == IDLE) ? ~(bus.in_sof_i & bus.in_sol_i) : bus.in_sof_i)
                  | (bus.in_sol_i & (col_q != '0))
                  | (~bus.in_eol_i & ((cur_col == CW'(W_MAX - 1)) | bus.in_eof_i));
            keep       = ~fault;
            frame_done = keep & bus.in_eol_i & bus.in_eof_i;
            if (fault) begin
                err_d   = 1'b1;
                state_d = IDLE;
                col_d   = '0;
            end else begin
                col_d  = bus.in_eol_i ? '0 : cur_col + 1'b1;
                rows_d = rows_cur;
                if (bus.in_eol_i && (rows_cur != RW'(LB_N))) begin
                    rows_d = rows_cur + 1'b1;
                end
                if (frame_done) begin
                    state_d = IDLE;
                end else if (rows_d == RW'(LB_N)) begin
                    state_d = STEADY;
                end else begin
                    state_d = FILL;
                end
            end
        end
        head.push = keep;
        head.sol  = keep & bus.in_sol_i;
        head.eol  = keep & bus.in_eol_i;
        head.win  = keep & (state_q == STEADY);
        head.rows = rows_cur;
    end

    // Stage i taps the delay line LAT*i cycles behind stage 0.
    always_comb begin
        bus.lb_push_o    = '0;
        bus.lb_pop_o     = '0;
        bus.lb_sol_o     = '0;
        bus.lb_eol_o     = '0;
        bus.lb_push_o[0] = head.push;
        bus.lb_pop_o[0]  = head.push & (rows_cur != '0);
        bus.lb_sol_o[0]  = head.sol;
        bus.lb_eol_o[0]  = head.eol;
        for (int i = 1; i < LB_N; i++) begin
            bus.lb_push_o[i] = pipe_q[LAT*i-1].push;
            bus.lb_pop_o[i]  = pipe_q[LAT*i-1].push & (int'(pipe_q[LAT*i-1].rows) > i);
            bus.lb_sol_o[i]  = pipe_q[LAT*i-1].sol;
            bus.lb_eol_o[i]  = pipe_q[LAT*i-1].eol;
        end
    end

    assign bus.win_vld_o = pipe_q[D-1].win;
    assign bus.win_eol_o = pipe_q[D-1].win & pipe_q[D-1].eol;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < D; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            col_q     <= col_d;
            err_q     <= err_d;
            pipe_q[0] <= head;
            for (int k = 1; k < D; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

`ifdef CONV_LB_SEQ_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (bus.in_vld_i && !bus.out_rdy_i) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif
endmodule
